// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stages: state encoding and default payload constants.
package pipe_pkg;

   // Encoding doubles as the live-entry count (EMPTY=0, ONE=1, FULL=2).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   localparam int          PIPE_DATA_W       = 64;
   localparam logic [63:0] PIPE_NOP_DEFAULT  = 64'h0000_0000_0000_0000;
   // Lower half (e.g. the address field) survives a flush; upper half becomes NOP.
   localparam logic [63:0] PIPE_KEEP_DEFAULT = 64'h0000_0000_FFFF_FFFF;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between an upstream producer, the skid stage and a downstream consumer.
//
// Handshake rules: a transfer happens on a rising clk edge exactly when valid and ready
// are both high. A producer holding valid keeps its data stable until the transfer.
// ready never depends combinationally on the same-cycle valid or on the opposite side.
// flush is a control strobe that discards held and incoming entries in its cycle.
interface pipe_skid_stage_if #(
   parameter int DATA_W = 64
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   // Environment side: drives upstream payload, flush and downstream ready.
   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   // Stage side.
   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage: main register drives out_data, skid register catches
// the one entry that arrives while downstream stalls. in_ready comes from registered
// state only, so no combinational path runs from out_ready back to in_ready.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = PIPE_DATA_W,
   parameter logic [DATA_W-1:0] NOP_VAL   = DATA_W'(PIPE_NOP_DEFAULT),
   parameter logic [DATA_W-1:0] KEEP_MASK = DATA_W'(PIPE_KEEP_DEFAULT)
) (
   input  logic                     clk,
   input  logic                     reset,
   pipe_skid_stage_if.slave         bus,
   output pipe_state_e              dbg_state
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q,  main_d;
   logic [DATA_W-1:0] skid_q,  skid_d;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer   = bus.in_valid  & bus.in_ready;
   assign out_xfer  = bus.out_valid & bus.out_ready;
   assign dbg_state = state_q;

   // Registered-state outputs: ready/valid/occupancy decode state_q only.
   always_comb begin
      bus.in_ready  = 1'b1;
      bus.out_valid = 1'b0;
      bus.occupancy = 2'd0;
      bus.out_data  = main_q;
      case (state_q)
         ST_EMPTY: begin
            bus.in_ready  = 1'b1;
            bus.out_valid = 1'b0;
            bus.occupancy = 2'd0;
         end
         ST_ONE: begin
            bus.in_ready  = 1'b1;
            bus.out_valid = 1'b1;
            bus.occupancy = 2'd1;
         end
         ST_FULL: begin
            bus.in_ready  = 1'b0;
            bus.out_valid = 1'b1;
            bus.occupancy = 2'd2;
         end
         default: begin
            bus.in_ready  = 1'b1;
            bus.out_valid = 1'b0;
            bus.occupancy = 2'd0;
         end
      endcase
   end

   // Next-state and register-load decisions; flush overrides every transfer.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (bus.flush) begin
         // A same-cycle out-transfer still counts as delivered; only the
         // payload field outside KEEP_MASK is replaced with the NOP pattern.
         state_d = ST_EMPTY;
         main_d  = (main_q & KEEP_MASK) | (NOP_VAL & ~KEEP_MASK);
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_d  = bus.in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_d = bus.in_data;
               end else if (in_xfer) begin
                  skid_d  = bus.in_data;
                  state_d = ST_FULL;
               end else if (out_xfer) begin
                  // main keeps its last value so out_data does not glitch to zero
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (bus.out_ready) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and payload registers; reset wins over flush and transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= NOP_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   // Skid contents are don't-care whenever state is not FULL, so no reset.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a long random run,
// with a queue-based reference of the stage contents and a decoupled monitor.
module tb_pipe_skid_stage;
   import pipe_pkg::*;

   localparam logic [63:0] NOP  = 64'h0000_0000_0000_0000;
   localparam logic [63:0] KEEP = 64'h0000_0000_FFFF_FFFF;

   logic        clk;
   logic        reset;
   pipe_state_e dbg_state;

   pipe_skid_stage_if #(.DATA_W(64)) bus ();

   pipe_skid_stage #(.DATA_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [63:0] exp_q[$];       // entries the stage should currently hold, oldest first
   logic [63:0] exp_hold;       // out_data expected while nothing is live
   logic        pend_valid;     // entry accepted at the coming edge
   logic [63:0] pend_data;
   logic        mon_en;
   int          checks;
   int          failures;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- driver tasks ----------------
   // Apply one cycle of inputs just after a rising edge; decide from the model
   // whether the entry will be accepted at the next edge.
   task automatic drive(input logic iv, input logic [63:0] d, input logic ordy,
                        input logic fl, input logic rs, output logic acc);
      @(posedge clk);
      #1;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      bus.flush     = fl;
      reset         = rs;
      acc           = iv && (exp_q.size() < 2) && !fl && !rs;
      pend_valid    = acc;
      pend_data     = d;
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      drive(1'b0, 64'h0, ordy, 1'b0, 1'b0, acc);
   endtask

   // Keep offering d until the stage takes it, bounded.
   task automatic push_until(input logic [63:0] d, input logic ordy);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 8) begin
         drive(1'b1, d, ordy, 1'b0, 1'b0, acc);
         tries++;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: got no accept expected accept of %h", d);
      end
   endtask

   // ---------------- monitor ----------------
   // Midway through each cycle: compare DUT outputs against the model, then
   // advance the model by what the coming edge will do.
   always @(negedge clk) begin
      if (mon_en) begin
         int          n;
         logic [63:0] cur;
         n   = exp_q.size();
         cur = (n > 0) ? exp_q[0] : exp_hold;
         chk("in_ready",  {63'd0, bus.in_ready},  {63'd0, n < 2});
         chk("out_valid", {63'd0, bus.out_valid}, {63'd0, n > 0});
         chk("occupancy", {62'd0, bus.occupancy}, 64'(n));
         chk("dbg_state", {62'd0, dbg_state},
             (n == 0) ? {62'd0, ST_EMPTY} : (n == 1) ? {62'd0, ST_ONE} : {62'd0, ST_FULL});
         chk("out_data",  bus.out_data, cur);
         if (reset) begin
            exp_q.delete();
            exp_hold = NOP;
         end else begin
            if (n > 0 && bus.out_ready) begin
               exp_hold = exp_q.pop_front();
            end
            if (bus.flush) begin
               exp_q.delete();
               exp_hold = (cur & KEEP) | (NOP & ~KEEP);
            end else if (pend_valid) begin
               exp_q.push_back(pend_data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic acc;
      logic [63:0] d;
      checks        = 0;
      failures      = 0;
      mon_en        = 1'b0;
      exp_hold      = NOP;
      pend_valid    = 1'b0;
      pend_data     = 64'h0;
      reset         = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 64'h0;
      bus.out_ready = 1'b0;

      drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, acc);
      drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, acc);
      mon_en = 1'b1;
      idle(1'b1);

      // Streaming: 1,2,3 back to back with out_ready high.
      push_until(64'd1, 1'b1);
      push_until(64'd2, 1'b1);
      push_until(64'd3, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("stream_drained_hold", bus.out_data, 64'd3);

      // Stall fill: A, B into a stalled stage, C held off, then release.
      push_until(64'hA, 1'b0);
      push_until(64'hB, 1'b0);
      drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, acc);
      chk("stall_c_refused", {63'd0, acc}, 64'd0);
      chk("stall_occ2", {62'd0, bus.occupancy}, 64'd2);
      push_until(64'hC, 1'b1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush from FULL with an input offered in the same cycle.
      push_until(64'hAAAA_BBBB_1234_5678, 1'b0);
      push_until(64'h1111_2222_3333_4444, 1'b0);
      drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1, 1'b0, acc);
      idle(1'b0);
      chk("flush_out_data",  bus.out_data, 64'h0000_0000_1234_5678);
      chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("flush_occ",       {62'd0, bus.occupancy}, 64'd0);
      idle(1'b1);

      // Reset together with flush while FULL.
      push_until(64'h5555_6666_7777_8888, 1'b0);
      push_until(64'h9999_AAAA_BBBB_CCCC, 1'b0);
      drive(1'b1, 64'h1, 1'b1, 1'b1, 1'b1, acc);
      idle(1'b0);
      chk("rst_flush_out_data", bus.out_data, NOP);
      chk("rst_flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst_flush_occ",      {62'd0, bus.occupancy}, 64'd0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 10000; i++) begin
         d = {$urandom(), $urandom()};
         drive(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 63) == 0), ($urandom_range(0, 255) == 0), acc);
         if ((i % 16) == 0 && !reset) begin
            // in_ready must not follow a same-cycle change of out_ready
            bus.out_ready = ~bus.out_ready;
            #1;
            chk("in_ready_indep", {63'd0, bus.in_ready}, {63'd0, exp_q.size() < 2});
            bus.out_ready = ~bus.out_ready;
         end
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
